hub75_scan_driver: RTL and testbench



---
 rtl/hub75_pkg.sv | 34 +++
 rtl/hub75_scan_driver_bcm_timer.sv | 36 +++
 rtl/hub75_scan_driver.sv | 183 ++++++++++++++++++
 tb/tb_hub75_scan_driver.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hub75_pkg.sv
// ============================================================================
// Module   : hub75_pkg
// Purpose  : Shared state encoding, RGB565 field positions and RAM address
//            packing for the HUB75 scan driver.
// Revision : 1.0
// ============================================================================
`default_nettype none

package hub75_pkg;

    localparam logic [1:0] c_ST_SHIFT   = 2'd0;
    localparam logic [1:0] c_ST_LATCH   = 2'd1;
    localparam logic [1:0] c_ST_DISPLAY = 2'd2;
    localparam logic [1:0] c_ST_BLANK   = 2'd3;

    localparam int c_R_LSB = 11;
    localparam int c_G_LSB = 5;
    localparam int c_B_LSB = 0;

    function automatic logic [10:0] pack_addr(input logic [4:0] row, input logic [5:0] col);
        return {row, col};
    endfunction

    // Green is one bit wider than red/blue; its LSB is dropped so all three
    // channels share the same 5-plane weighting.
    function automatic logic [2:0] plane_bits(input logic [15:0] pix, input logic [2:0] plane);
        logic [15:0] w_sh;
        w_sh = pix >> plane;
        return {w_sh[c_R_LSB], w_sh[c_G_LSB + 1], w_sh[c_B_LSB]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/hub75_scan_driver_bcm_timer.sv
// ============================================================================
// Module   : bcm_timer
// Purpose  : Down-counter for the display interval; done while count is zero.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bcm_timer #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_load,
    input  logic [W-1:0] i_ticks,
    output logic         o_done
);

    localparam logic [W-1:0] c_ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_ticks - c_ONE;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - c_ONE;
        end
    end

    assign o_done = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/hub75_scan_driver.sv
// ============================================================================
// Module   : hub75_scan_driver
// Purpose  : Scans a dual-bank pixel RAM into a HUB75 panel with 5-bit BCM.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hub75_scan_driver
    import hub75_pkg::*;
#(
    parameter int COLS       = 64,
    parameter int ROW_BITS   = 5,
    parameter int PLANES     = 5,
    parameter int BASE_TICKS = 8
) (
    input  logic                i_clk,
    input  logic                i_reset,
    output logic [10:0]         o_r_addr,
    output logic                o_r_enable,
    input  logic [15:0]         i_bank1_data,
    input  logic [15:0]         i_bank2_data,
    output logic                o_r1,
    output logic                o_g1,
    output logic                o_b1,
    output logic                o_r2,
    output logic                o_g2,
    output logic                o_b2,
    output logic                o_panel_clk,
    output logic                o_lat,
    output logic                o_oe_n,
    output logic [ROW_BITS-1:0] o_row_addr,
    output logic                o_frame_done
);

    localparam int CYC_W  = $clog2(2 * COLS + 1);
    localparam int TICK_W = $clog2(BASE_TICKS << (PLANES - 1)) + 1;

    logic [1:0]          r_state;
    logic [CYC_W-1:0]    r_cyc;
    logic [ROW_BITS-1:0] r_row;
    logic [2:0]          r_plane;
    logic                r_primed;
    logic                r_r_en;
    logic [10:0]         r_r_addr;
    logic                r_rd_q;
    logic [15:0]         r_pix1;
    logic [15:0]         r_pix2;
    logic                r_odd;
    logic [5:0]          r_hold;
    logic                r_pclk;
    logic                r_lat;
    logic                r_oe_n;
    logic [ROW_BITS-1:0] r_row_addr;
    logic                r_frame_done;

    logic [15:0]         w_pix1;
    logic [15:0]         w_pix2;
    logic [5:0]          w_bits;
    logic                w_plane_wrap;
    logic [2:0]          w_plane_next;
    logic [ROW_BITS-1:0] w_row_next;
    logic                w_frame_last;
    logic [CYC_W-1:0]    w_col_cur;
    logic [TICK_W-1:0]   w_ticks;
    logic                w_done;

    // Column 0 arrives the cycle it is shown, later columns one cycle early,
    // so odd shift cycles take live RAM data when a read has just returned.
    always_comb begin
        w_pix1       = r_rd_q ? i_bank1_data : r_pix1;
        w_pix2       = r_rd_q ? i_bank2_data : r_pix2;
        w_bits       = {plane_bits(w_pix1, r_plane), plane_bits(w_pix2, r_plane)};
        w_plane_wrap = (r_plane == 3'(PLANES - 1));
        w_plane_next = w_plane_wrap ? 3'd0 : r_plane + 3'd1;
        w_row_next   = w_plane_wrap ? r_row + ROW_BITS'(1) : r_row;
        w_frame_last = w_plane_wrap && (r_row == {ROW_BITS{1'b1}});
        w_col_cur    = r_cyc >> 1;
        w_ticks      = TICK_W'(BASE_TICKS) << r_plane;
    end

    bcm_timer #(
        .W(TICK_W)
    ) u_bcm_timer (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_load  (r_state == c_ST_LATCH),
        .i_ticks (w_ticks),
        .o_done  (w_done)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= c_ST_SHIFT;
            r_cyc        <= '0;
            r_row        <= '0;
            r_plane      <= '0;
            r_primed     <= 1'b0;
            r_r_en       <= 1'b0;
            r_r_addr     <= '0;
            r_rd_q       <= 1'b0;
            r_pix1       <= '0;
            r_pix2       <= '0;
            r_odd        <= 1'b0;
            r_hold       <= '0;
            r_pclk       <= 1'b0;
            r_lat        <= 1'b0;
            r_oe_n       <= 1'b1;
            r_row_addr   <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_r_en       <= 1'b0;
            r_lat        <= 1'b0;
            r_frame_done <= 1'b0;
            r_rd_q       <= r_r_en;
            if (r_rd_q) begin
                r_pix1 <= i_bank1_data;
                r_pix2 <= i_bank2_data;
            end
            if (r_odd) begin
                r_hold <= w_bits;
            end
            case (r_state)
                c_ST_SHIFT: begin
                    if (!r_primed) begin
                        r_primed <= 1'b1;
                        r_r_en   <= 1'b1;
                        r_r_addr <= pack_addr(5'(r_row), 6'd0);
                    end else if (r_cyc == CYC_W'(2 * COLS)) begin
                        r_state    <= c_ST_LATCH;
                        r_pclk     <= 1'b0;
                        r_odd      <= 1'b0;
                        r_lat      <= 1'b1;
                        r_row_addr <= r_row;
                    end else begin
                        r_cyc <= r_cyc + CYC_W'(1);
                        if (!r_cyc[0]) begin
                            r_pclk <= 1'b0;
                            r_odd  <= 1'b1;
                            if (w_col_cur < CYC_W'(COLS - 1)) begin
                                r_r_en   <= 1'b1;
                                r_r_addr <= pack_addr(5'(r_row), 6'(w_col_cur) + 6'd1);
                            end
                        end else begin
                            r_pclk <= 1'b1;
                            r_odd  <= 1'b0;
                        end
                    end
                end
                c_ST_LATCH: begin
                    r_state <= c_ST_DISPLAY;
                    r_oe_n  <= 1'b0;
                end
                c_ST_DISPLAY: begin
                    if (w_done) begin
                        r_state      <= c_ST_BLANK;
                        r_oe_n       <= 1'b1;
                        r_frame_done <= w_frame_last;
                    end
                end
                default: begin
                    r_state  <= c_ST_SHIFT;
                    r_cyc    <= '0;
                    r_plane  <= w_plane_next;
                    r_row    <= w_row_next;
                    r_r_en   <= 1'b1;
                    r_r_addr <= pack_addr(5'(w_row_next), 6'd0);
                end
            endcase
        end
    end

    assign o_r_addr     = r_r_addr;
    assign o_r_enable   = r_r_en;
    assign o_panel_clk  = r_pclk;
    assign o_lat        = r_lat;
    assign o_oe_n       = r_oe_n;
    assign o_row_addr   = r_row_addr;
    assign o_frame_done = r_frame_done;
    assign {o_r1, o_g1, o_b1, o_r2, o_g2, o_b2} = r_odd ? w_bits : r_hold;

endmodule

`default_nettype wire

// File: tb/tb_hub75_scan_driver.sv
// ============================================================================
// Module   : tb_hub75_scan_driver
// Purpose  : Self-checking bench with a 1-cycle-latency RAM model.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_hub75_scan_driver;

    localparam int COLS       = 4;
    localparam int ROW_BITS   = 2;
    localparam int PLANES     = 5;
    localparam int BASE_TICKS = 2;
    localparam int NROWS      = 1 << ROW_BITS;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [10:0]         r_addr;
    logic                r_en;
    logic [15:0]         d1 = '0;
    logic [15:0]         d2 = '0;
    logic                r1, g1, b1, r2, g2, b2;
    logic                pclk, lat, oe_n, fdone;
    logic [ROW_BITS-1:0] row_addr;

    logic [15:0] mem1 [2048];
    logic [15:0] mem2 [2048];

    int n_cmp = 0;
    int n_bad = 0;
    int g_cmp = 0;
    int g_bad = 0;

    always #5 clk = ~clk;

    hub75_scan_driver #(
        .COLS(COLS), .ROW_BITS(ROW_BITS), .PLANES(PLANES), .BASE_TICKS(BASE_TICKS)
    ) dut (
        .i_clk(clk), .i_reset(rst),
        .o_r_addr(r_addr), .o_r_enable(r_en),
        .i_bank1_data(d1), .i_bank2_data(d2),
        .o_r1(r1), .o_g1(g1), .o_b1(b1), .o_r2(r2), .o_g2(g2), .o_b2(b2),
        .o_panel_clk(pclk), .o_lat(lat), .o_oe_n(oe_n),
        .o_row_addr(row_addr), .o_frame_done(fdone)
    );

    always @(posedge clk) begin
        if (r_en) begin
            d1 <= mem1[r_addr];
            d2 <= mem2[r_addr];
        end
    end

    // Panel-side rule: nothing visible may move while the LEDs are lit.
    logic                prev_oe_n = 1'b1;
    logic [ROW_BITS-1:0] prev_row  = '0;
    logic [5:0]          prev_col  = '0;
    always @(negedge clk) begin
        if (oe_n === 1'b0 && prev_oe_n === 1'b0) begin
            g_cmp++;
            if ({row_addr, r1, g1, b1, r2, g2, b2} !== {prev_row, prev_col}) begin
                g_bad++;
                $display("FAIL anti_ghost t=%0t row/colour now %b/%b, held %b/%b", $time,
                         row_addr, {r1, g1, b1, r2, g2, b2}, prev_row, prev_col);
            end
        end
        prev_oe_n = oe_n;
        prev_row  = row_addr;
        prev_col  = {r1, g1, b1, r2, g2, b2};
    end

    function automatic logic [2:0] exp_bits(input logic [15:0] pix, input int p);
        int rf, gf, bf;
        rf = int'(pix[15:11]);
        gf = int'(pix[10:5]);
        bf = int'(pix[4:0]);
        return {1'(rf >> p), 1'(gf >> (p + 1)), 1'(bf >> p)};
    endfunction

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int k;
        do_reset(3);
        k = 0;
        while (!(oe_n === 1'b0 && row_addr != '0) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (k >= 3000) begin
            n_bad++;
            $display("FAIL reset_reach_display: waited %0d cycles, limit 3000", k);
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (oe_n !== 1'b1) begin n_bad++; $display("FAIL reset_oe_n got %b exp 1", oe_n); end
        n_cmp++; if (lat !== 1'b0) begin n_bad++; $display("FAIL reset_lat got %b exp 0", lat); end
        n_cmp++; if (row_addr !== '0) begin n_bad++; $display("FAIL reset_row_addr got %0d exp 0", row_addr); end
        n_cmp++; if (fdone !== 1'b0) begin n_bad++; $display("FAIL reset_frame_done got %b exp 0", fdone); end
        n_cmp++; if (r_en !== 1'b0 || pclk !== 1'b0) begin
            n_bad++; $display("FAIL reset_en_pclk got %b%b exp 00", r_en, pclk);
        end
        n_cmp++; if ({r1, g1, b1, r2, g2, b2} !== 6'b0 || r_addr !== 11'd0) begin
            n_bad++; $display("FAIL reset_colour_addr got %b/%h exp 0/0", {r1, g1, b1, r2, g2, b2}, r_addr);
        end
        repeat (2) @(negedge clk);
        n_cmp++; if (oe_n !== 1'b1) begin n_bad++; $display("FAIL reset_hold_oe_n got %b exp 1", oe_n); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (r_en !== 1'b1 || r_addr !== 11'd0) begin
            n_bad++; $display("FAIL reset_release_read got en=%b addr=%h exp en=1 addr=000", r_en, r_addr);
        end
    endtask

    task automatic test_shift_planes();
        logic [15:0] pat[4];
        logic [2:0]  exp1[4];
        logic [10:0] aq[$];
        int          acq[$];
        logic [2:0]  s1q[$];
        logic [2:0]  s2q[$];
        logic        prev_pclk;
        int          cyc;
        pat  = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFFF};
        exp1 = '{3'b100, 3'b010, 3'b001, 3'b111};
        for (int c = 0; c < COLS; c++) begin
            mem1[c] = pat[c];
            mem2[c] = 16'h0000;
        end
        do_reset(3);
        cyc = 0;
        prev_pclk = 1'b0;
        while (lat !== 1'b1 && cyc < 200) begin
            if (r_en === 1'b1) begin
                aq.push_back(r_addr);
                acq.push_back(cyc);
            end
            if (pclk === 1'b1 && prev_pclk === 1'b0) begin
                s1q.push_back({r1, g1, b1});
                s2q.push_back({r2, g2, b2});
            end
            prev_pclk = pclk;
            @(negedge clk);
            cyc++;
        end
        n_cmp++; if (cyc >= 200) begin n_bad++; $display("FAIL shift_lat_timeout: no latch within %0d cycles", cyc); end
        n_cmp++; if (s1q.size() != COLS) begin n_bad++; $display("FAIL shift_edge_count got %0d exp %0d", s1q.size(), COLS); end
        n_cmp++; if (aq.size() != COLS) begin n_bad++; $display("FAIL read_count got %0d exp %0d", aq.size(), COLS); end
        n_cmp++; if (row_addr !== '0 || oe_n !== 1'b1) begin
            n_bad++; $display("FAIL latch_row got row=%0d oe_n=%b exp row=0 oe_n=1", row_addr, oe_n);
        end
        for (int k = 0; k < COLS; k++) begin
            if (k < s1q.size()) begin
                n_cmp++;
                if (s1q[k] !== exp1[k] || s2q[k] !== 3'b000) begin
                    n_bad++;
                    $display("FAIL shift_col%0d got %b/%b exp %b/000", k, s1q[k], s2q[k], exp1[k]);
                end
            end
            if (k < aq.size()) begin
                n_cmp++;
                if (aq[k] !== 11'(k)) begin
                    n_bad++; $display("FAIL read_addr%0d got %h exp %h", k, aq[k], 11'(k));
                end
                if (k > 0) begin
                    n_cmp++;
                    if (acq[k] - acq[k-1] != ((k == 1) ? 1 : 2)) begin
                        n_bad++;
                        $display("FAIL read_spacing%0d got %0d exp %0d", k, acq[k] - acq[k-1], (k == 1) ? 1 : 2);
                    end
                end
            end
        end
    endtask

    task automatic test_bcm_timing();
        int k;
        int len;
        do_reset(2);
        for (int p = 0; p < PLANES; p++) begin
            k = 0;
            while (lat !== 1'b1 && k < 300) begin
                @(negedge clk);
                k++;
            end
            @(negedge clk);
            len = 0;
            while (oe_n === 1'b0 && len < 200) begin
                len++;
                @(negedge clk);
            end
            n_cmp++;
            if (k >= 300 || len != (BASE_TICKS << p)) begin
                n_bad++;
                $display("FAIL bcm_plane%0d got run %0d (lat wait %0d) exp %0d", p, len, k, BASE_TICKS << p);
            end
        end
    endtask

    task automatic test_frame_walk();
        int          period;
        int          n_lat;
        int          col;
        int          cyc;
        int          last_fd;
        int          fd_cnt;
        int          p;
        int          row;
        logic        prev_pclk;
        logic        prev_fd;
        logic [10:0] a;
        logic [5:0]  exp;
        int          rows_q[$];
        int          exp_rows[5];
        period = 0;
        for (int q = 0; q < PLANES; q++) period += 2 * COLS + 3 + (BASE_TICKS << q);
        period *= NROWS;
        exp_rows = '{0, 1, 2, 3, 0};
        for (int r = 0; r < NROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                mem1[r * 64 + c] = 16'($urandom);
                mem2[r * 64 + c] = 16'($urandom);
            end
        end
        do_reset(3);
        n_lat = 0; col = 0; cyc = 0; last_fd = -1; fd_cnt = 0;
        prev_pclk = 1'b0; prev_fd = 1'b0;
        while (fd_cnt < 2 && cyc < 1500) begin
            p   = n_lat % PLANES;
            row = (n_lat / PLANES) % NROWS;
            if (pclk === 1'b1 && prev_pclk === 1'b0) begin
                a   = 11'(row * 64 + col);
                exp = {exp_bits(mem1[a], p), exp_bits(mem2[a], p)};
                n_cmp++;
                if ({r1, g1, b1, r2, g2, b2} !== exp) begin
                    n_bad++;
                    $display("FAIL walk_pix row%0d col%0d plane%0d got %b exp %b", row, col, p,
                             {r1, g1, b1, r2, g2, b2}, exp);
                end
                col++;
            end
            if (lat === 1'b1) begin
                n_cmp++;
                if (col != COLS || row_addr !== ROW_BITS'(row)) begin
                    n_bad++;
                    $display("FAIL walk_latch pass%0d got edges=%0d row=%0d exp edges=%0d row=%0d",
                             n_lat, col, row_addr, COLS, row);
                end
                if (p == 0) rows_q.push_back(int'(row_addr));
                n_lat++;
                col = 0;
            end
            if (fdone === 1'b1) begin
                n_cmp++;
                if (prev_fd === 1'b1 || n_lat == 0 || n_lat % (PLANES * NROWS) != 0) begin
                    n_bad++;
                    $display("FAIL walk_frame_done_place got passes=%0d prev=%b exp multiple of %0d, single pulse",
                             n_lat, prev_fd, PLANES * NROWS);
                end
                if (last_fd >= 0) begin
                    n_cmp++;
                    if (cyc - last_fd != period) begin
                        n_bad++; $display("FAIL walk_frame_period got %0d exp %0d", cyc - last_fd, period);
                    end
                end
                last_fd = cyc;
                fd_cnt++;
            end
            prev_pclk = pclk;
            prev_fd   = fdone;
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (fd_cnt < 2) begin n_bad++; $display("FAIL walk_frame_count got %0d exp 2 within 1500 cycles", fd_cnt); end
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if (k >= rows_q.size() || rows_q[k] != exp_rows[k]) begin
                n_bad++;
                $display("FAIL walk_row_seq%0d got %0d exp %0d", k, (k < rows_q.size()) ? rows_q[k] : -1, exp_rows[k]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) begin
            mem1[i] = 16'($urandom);
            mem2[i] = 16'($urandom);
        end
        test_reset();
        test_shift_planes();
        test_bcm_timing();
        test_frame_walk();
        test_frame_walk();
        n_cmp += g_cmp;
        n_bad += g_bad;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
